// File: rtl/extensor_pkg.sv
// Shared definitions for the immediate sign-extension block and its result queue.
package extensor_pkg;

  // Operation selected by Modo, sampled together with Entrada.
  typedef enum logic [1:0] {
    MODO_ZERO    = 2'b00,  // zero-extend
    MODO_SINAL   = 2'b01,  // sign-extend
    MODO_DESLOC1 = 2'b10,  // sign-extend, shift left by 1
    MODO_DESLOCN = 2'b11   // sign-extend, shift left by SHIFT
  } modo_e;

endpackage

// File: rtl/fila_extensor.sv
// Small ready/valid result queue. The head entry is presented combinationally,
// so a write into an empty queue is visible on rd_data the cycle after it lands.
// wr_ready depends only on the registered occupancy, never on rd_ready.
module fila_extensor
  import extensor_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [W-1:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign wr_ready = (count_q != CNT_MAX);
  assign rd_valid = (count_q != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // Empty queue drives zeros so the outputs are stable and match the reset value.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  // Pointer and occupancy update; pointers wrap explicitly so any DEPTH works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage write: only the tail slot changes on an accepted write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (push && (wr_ptr_q == PTR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Control state with asynchronous clear; stale storage is hidden by rd_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage register array, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/extensor_sinal_fila.sv
// Immediate extender: zero/sign extension with optional left shift and overflow
// flag, followed by a small result queue with ready/valid on both sides.
module extensor_sinal_fila
  import extensor_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 8,
  parameter int SHIFT = 2,
  parameter int DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [IN_W-1:0]  Entrada,
  input  logic [1:0]       Modo,
  input  logic             ValidoEntrada,
  output logic             ProntoEntrada,
  output logic [OUT_W-1:0] Resultado,
  output logic             Truncado,
  output logic             ValidoSaida,
  input  logic             ProntoSaida
);

  // Parameter sanity: refuse to elaborate impossible configurations.
  if (!(OUT_W > IN_W && IN_W >= 2)) begin : g_bad_width
    $error("extensor_sinal_fila: need OUT_W > IN_W >= 2");
  end
  if (!(SHIFT >= 1 && SHIFT < OUT_W)) begin : g_bad_shift
    $error("extensor_sinal_fila: need 1 <= SHIFT < OUT_W");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("extensor_sinal_fila: need DEPTH >= 1");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [1:0]       top_1;
  logic [SHIFT:0]   top_n;
  logic [OUT_W-1:0] res;
  logic             trunc;
  logic [OUT_W:0]   head;

  assign zext = {{(OUT_W - IN_W){1'b0}}, Entrada};
  assign sext = {{(OUT_W - IN_W){Entrada[IN_W-1]}}, Entrada};

  // Bits that become the shifted-out bits plus the new MSB; the shift is lossless
  // only when they are all copies of the sign bit.
  assign top_1 = sext[OUT_W-1 -: 2];
  assign top_n = sext[OUT_W-1 -: SHIFT + 1];

  // Extension, shift and truncation detection for the selected mode.
  always_comb begin
    res   = zext;
    trunc = 1'b0;
    case (modo_e'(Modo))
      MODO_ZERO: begin
        res = zext;
      end
      MODO_SINAL: begin
        res = sext;
      end
      MODO_DESLOC1: begin
        res   = sext << 1;
        trunc = !((&top_1) || !(|top_1));
      end
      MODO_DESLOCN: begin
        res   = sext << SHIFT;
        trunc = !((&top_n) || !(|top_n));
      end
      default: begin
        res   = zext;
        trunc = 1'b0;
      end
    endcase
  end

  fila_extensor #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fila (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .wr_valid (ValidoEntrada),
    .wr_ready (ProntoEntrada),
    .wr_data  ({trunc, res}),
    .rd_valid (ValidoSaida),
    .rd_ready (ProntoSaida),
    .rd_data  (head)
  );

  assign Truncado  = head[OUT_W];
  assign Resultado = head[OUT_W-1:0];

endmodule
